// File: rtl/serial_transceiver_fifo_if.sv
// Bus bundle for serial_transceiver_fifo: core word bus, serial link pins,
// loopback control, status flags and FIFO occupancy.
interface serial_transceiver_fifo_if #(
  parameter int BANDWIDTH  = 1,
  parameter int WORD_SIZE  = 8,
  parameter int BUFFER_OUT = 4,
  parameter int BUFFER_IN  = 4
);
  localparam int LVL_OUT_W = $clog2(BUFFER_OUT + 1);
  localparam int LVL_IN_W  = $clog2(BUFFER_IN + 1);

  logic                 adv_send;
  logic [WORD_SIZE-1:0] send;
  logic                 send_buff_ready;
  logic                 adv_recv;
  logic [WORD_SIZE-1:0] recv;
  logic                 recv_buff_ready;
  logic [BANDWIDTH-1:0] tx;
  logic                 tx_valid;
  logic                 tx_start;
  logic [BANDWIDTH-1:0] rx;
  logic                 rx_valid;
  logic                 rx_start;
  logic                 loopback;
  logic                 rx_overflow;
  logic                 rx_frame_err;
  logic [LVL_OUT_W-1:0] tx_level;
  logic [LVL_IN_W-1:0]  rx_level;

  modport master (
    output adv_send, send, adv_recv, rx, rx_valid, rx_start, loopback,
    input  send_buff_ready, recv, recv_buff_ready, tx, tx_valid, tx_start,
           rx_overflow, rx_frame_err, tx_level, rx_level
  );

  modport slave (
    input  adv_send, send, adv_recv, rx, rx_valid, rx_start, loopback,
    output send_buff_ready, recv, recv_buff_ready, tx, tx_valid, tx_start,
           rx_overflow, rx_frame_err, tx_level, rx_level
  );
endinterface

// File: rtl/serial_transceiver_fifo.sv
// Full-duplex serial transceiver: word TX FIFO feeding a gap-free LSB-first
// serialiser, and a framed deserialiser feeding a show-ahead RX FIFO, with
// internal loopback and sticky overflow / framing error flags.
module serial_transceiver_fifo #(
  parameter int BANDWIDTH  = 1,
  parameter int WORD_SIZE  = 8,
  parameter int BUFFER_OUT = 4,
  parameter int BUFFER_IN  = 4
) (
  input logic                      clock,
  input logic                      reset,
  serial_transceiver_fifo_if.slave bus
);
  localparam int BEATS     = WORD_SIZE / BANDWIDTH;
  localparam int LVL_OUT_W = $clog2(BUFFER_OUT + 1);
  localparam int LVL_IN_W  = $clog2(BUFFER_IN + 1);
  localparam int TXP_W     = (BUFFER_OUT > 1) ? $clog2(BUFFER_OUT) : 1;
  localparam int RXP_W     = (BUFFER_IN > 1) ? $clog2(BUFFER_IN) : 1;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

  generate
    if ((WORD_SIZE % BANDWIDTH) != 0) begin : g_badWidth
      $error("serial_transceiver_fifo: WORD_SIZE must be a multiple of BANDWIDTH");
    end
  endgenerate

  typedef enum logic {TX_IDLE, TX_SHIFT} txState_t;

  // TX side state
  logic [WORD_SIZE-1:0] r_txMem [BUFFER_OUT];
  logic [TXP_W-1:0]     r_txWr, r_txRd;
  logic [LVL_OUT_W-1:0] r_txLevel;
  txState_t             r_txState, w_txStateNext;
  logic [WORD_SIZE-1:0] r_txShift;
  logic [BEAT_W-1:0]    r_txBeat;
  logic [BANDWIDTH-1:0] r_tx;
  logic                 r_txValid, r_txStart;

  // RX side state
  logic [WORD_SIZE-1:0] r_rxMem [BUFFER_IN];
  logic [RXP_W-1:0]     r_rxWr, r_rxRd;
  logic [LVL_IN_W-1:0]  r_rxLevel;
  logic [BEAT_W-1:0]    r_rxIdx;
  logic [WORD_SIZE-1:0] r_rxWord;
  logic                 r_rxOverflow, r_rxFrameErr;

  logic                 w_txNotFull, w_txNotEmpty, w_txPush, w_txPop, w_txLastBeat;
  logic [WORD_SIZE-1:0] w_txHead;
  logic [BANDWIDTH-1:0] w_srcData;
  logic                 w_srcValid, w_srcStart;
  logic [BEAT_W-1:0]    w_capIdx;
  logic [WORD_SIZE-1:0] w_rxAssembled;
  logic                 w_rxDone, w_rxFull, w_rxPop, w_rxPush, w_rxDrop;

  function automatic logic [TXP_W-1:0] txPtrNext(input logic [TXP_W-1:0] p);
    return (p == TXP_W'(BUFFER_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [RXP_W-1:0] rxPtrNext(input logic [RXP_W-1:0] p);
    return (p == RXP_W'(BUFFER_IN - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------- TX path ----------------
  assign w_txNotFull  = (r_txLevel < LVL_OUT_W'(BUFFER_OUT));
  assign w_txNotEmpty = (r_txLevel != '0);
  assign w_txHead     = r_txMem[r_txRd];
  assign w_txPush     = reset && bus.adv_send && w_txNotFull;
  assign w_txLastBeat = (r_txState == TX_SHIFT) && (r_txBeat == BEAT_W'(BEATS - 1));
  assign w_txPop      = reset && w_txNotEmpty && ((r_txState == TX_IDLE) || w_txLastBeat);

  // Store accepted words at the TX tail
  always_ff @(posedge clock) begin
    if (w_txPush) r_txMem[r_txWr] <= bus.send;
  end

  // TX pointers and occupancy (word in the shift register is not counted)
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_txWr    <= '0;
      r_txRd    <= '0;
      r_txLevel <= '0;
    end else begin
      if (w_txPush) r_txWr <= txPtrNext(r_txWr);
      if (w_txPop)  r_txRd <= txPtrNext(r_txRd);
      r_txLevel <= r_txLevel + LVL_OUT_W'(w_txPush) - LVL_OUT_W'(w_txPop);
    end
  end

  // Serialiser state register
  always_ff @(posedge clock) begin
    if (!reset) r_txState <= TX_IDLE;
    else        r_txState <= w_txStateNext;
  end

  // Serialiser next state: reloading on the last beat keeps the stream gap-free
  always_comb begin
    w_txStateNext = r_txState;
    case (r_txState)
      TX_IDLE:  if (w_txPop) w_txStateNext = TX_SHIFT;
      TX_SHIFT: if (w_txLastBeat && !w_txNotEmpty) w_txStateNext = TX_IDLE;
      default:  w_txStateNext = TX_IDLE;
    endcase
  end

  // Serialiser datapath: registered beat output, LSB-first shifting
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_txShift <= '0;
      r_txBeat  <= '0;
      r_tx      <= '0;
      r_txValid <= 1'b0;
      r_txStart <= 1'b0;
    end else if (w_txPop) begin
      r_tx      <= w_txHead[BANDWIDTH-1:0];
      r_txShift <= w_txHead >> BANDWIDTH;
      r_txBeat  <= '0;
      r_txValid <= 1'b1;
      r_txStart <= 1'b1;
    end else if (r_txState == TX_SHIFT) begin
      if (w_txLastBeat) begin
        r_tx      <= '0;
        r_txValid <= 1'b0;
        r_txStart <= 1'b0;
      end else begin
        r_tx      <= r_txShift[BANDWIDTH-1:0];
        r_txShift <= r_txShift >> BANDWIDTH;
        r_txBeat  <= r_txBeat + 1'b1;
        r_txStart <= 1'b0;
      end
    end
  end

  // ---------------- RX path ----------------
  assign w_srcData  = bus.loopback ? r_tx      : bus.rx;
  assign w_srcValid = bus.loopback ? r_txValid : bus.rx_valid;
  assign w_srcStart = bus.loopback ? r_txStart : bus.rx_start;
  assign w_capIdx   = w_srcStart ? '0 : r_rxIdx;
  assign w_rxDone   = reset && w_srcValid && (w_capIdx == BEAT_W'(BEATS - 1));
  assign w_rxFull   = (r_rxLevel == LVL_IN_W'(BUFFER_IN));
  assign w_rxPop    = reset && bus.adv_recv && (r_rxLevel != '0);
  assign w_rxPush   = w_rxDone && (!w_rxFull || w_rxPop);
  assign w_rxDrop   = w_rxDone && w_rxFull && !w_rxPop;

  // Partial word with the incoming beat dropped into its slot
  always_comb begin
    w_rxAssembled = r_rxWord;
    w_rxAssembled[int'(w_capIdx)*BANDWIDTH +: BANDWIDTH] = w_srcData;
  end

  // Deserialiser: beat index, partial word and sticky error flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rxIdx      <= '0;
      r_rxWord     <= '0;
      r_rxOverflow <= 1'b0;
      r_rxFrameErr <= 1'b0;
    end else begin
      if (w_srcValid) begin
        r_rxWord <= w_rxAssembled;
        r_rxIdx  <= w_rxDone ? '0 : w_capIdx + 1'b1;
        if (w_srcStart && (r_rxIdx != '0)) r_rxFrameErr <= 1'b1;
      end
      if (w_rxDrop) r_rxOverflow <= 1'b1;
    end
  end

  // Store completed words at the RX tail
  always_ff @(posedge clock) begin
    if (w_rxPush) r_rxMem[r_rxWr] <= w_rxAssembled;
  end

  // RX pointers and occupancy
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rxWr    <= '0;
      r_rxRd    <= '0;
      r_rxLevel <= '0;
    end else begin
      if (w_rxPush) r_rxWr <= rxPtrNext(r_rxWr);
      if (w_rxPop)  r_rxRd <= rxPtrNext(r_rxRd);
      r_rxLevel <= r_rxLevel + LVL_IN_W'(w_rxPush) - LVL_IN_W'(w_rxPop);
    end
  end

  assign bus.send_buff_ready = w_txNotFull;
  assign bus.recv            = r_rxMem[r_rxRd];
  assign bus.recv_buff_ready = (r_rxLevel != '0);
  assign bus.tx              = r_tx;
  assign bus.tx_valid        = r_txValid;
  assign bus.tx_start        = r_txStart;
  assign bus.rx_overflow     = r_rxOverflow;
  assign bus.rx_frame_err    = r_rxFrameErr;
  assign bus.tx_level        = r_txLevel;
  assign bus.rx_level        = r_rxLevel;
endmodule

// File: tb/tb_serial_transceiver_fifo.sv
// Scoreboard bench for serial_transceiver_fifo: a queue-based reference model
// predicts the TX beat stream, FIFO levels, RX contents and flags; a monitor
// compares the DUT against it on every falling edge.
module tb_serial_transceiver_fifo;
  localparam int BW    = 2;
  localparam int WS    = 8;
  localparam int BO    = 4;
  localparam int BI    = 4;
  localparam int BEATS = WS / BW;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          start;
  } beat_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   nChecks = 0;
  int   nPass = 0;

  always #5 clock = ~clock;

  serial_transceiver_fifo_if #(.BANDWIDTH(BW), .WORD_SIZE(WS), .BUFFER_OUT(BO), .BUFFER_IN(BI)) bus ();

  serial_transceiver_fifo #(.BANDWIDTH(BW), .WORD_SIZE(WS), .BUFFER_OUT(BO), .BUFFER_IN(BI)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Reference model state
  logic [WS-1:0] mTxQ[$];
  logic [WS-1:0] mRxQ[$];
  beat_t         expBeats[$];
  logic          mTxV = 1'b0;
  int            mBeatIdx = 0;
  logic [WS-1:0] mCurWord = '0;
  int            mRxCount = 0;
  logic [WS-1:0] mRxPart = '0;
  logic          mOvf = 1'b0;
  logic          mFerr = 1'b0;

  function automatic logic [BW-1:0] beatOf(input logic [WS-1:0] w, input int k);
    logic [WS-1:0] s;
    s = w >> (k * BW);
    return s[BW-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one link beat per cycle, words leave the TX queue when the link is free
  always @(posedge clock) begin
    logic          srcV, srcS, popRx, fullRx, readyTx;
    logic [BW-1:0] srcD;
    if (!reset) begin
      mTxQ.delete();
      mRxQ.delete();
      expBeats.delete();
      mTxV = 1'b0;
      mBeatIdx = 0;
      mRxCount = 0;
      mRxPart = '0;
      mOvf = 1'b0;
      mFerr = 1'b0;
    end else begin
      srcV = bus.loopback ? mTxV : bus.rx_valid;
      srcS = bus.loopback ? (mTxV && mBeatIdx == 0) : bus.rx_start;
      srcD = bus.loopback ? (mTxV ? beatOf(mCurWord, mBeatIdx) : '0) : bus.rx;
      fullRx = (mRxQ.size() == BI);
      popRx  = bus.adv_recv && (mRxQ.size() > 0);
      if (popRx) void'(mRxQ.pop_front());
      if (srcV) begin
        if (srcS) begin
          if (mRxCount != 0) mFerr = 1'b1;
          mRxCount = 0;
        end
        if (mRxCount == 0) mRxPart = '0;
        mRxPart = mRxPart | (WS'(srcD) << (mRxCount * BW));
        mRxCount++;
        if (mRxCount == BEATS) begin
          mRxCount = 0;
          if (fullRx && !popRx) mOvf = 1'b1;
          else mRxQ.push_back(mRxPart);
        end
      end
      readyTx = (mTxQ.size() < BO);
      if (!mTxV || mBeatIdx == BEATS - 1) begin
        if (mTxQ.size() > 0) begin
          mCurWord = mTxQ.pop_front();
          mBeatIdx = 0;
          mTxV = 1'b1;
          for (int k = 0; k < BEATS; k++) expBeats.push_back('{data: beatOf(mCurWord, k), start: (k == 0)});
        end else begin
          mTxV = 1'b0;
          mBeatIdx = 0;
        end
      end else begin
        mBeatIdx++;
      end
      if (bus.adv_send && readyTx) mTxQ.push_back(bus.send);
    end
  end

  // Monitor: compare DUT outputs with the model on every falling edge
  always @(negedge clock) begin
    beat_t e;
    checkOutput("tx_valid", bus.tx_valid, mTxV);
    if (bus.tx_valid) begin
      checkOutput("tx_beat_pending", expBeats.size() != 0, 1);
      if (expBeats.size() != 0) begin
        e = expBeats.pop_front();
        checkOutput("tx_data", bus.tx, e.data);
        checkOutput("tx_start", bus.tx_start, e.start);
      end
    end else begin
      checkOutput("tx_idle_data", {bus.tx, bus.tx_start}, 0);
    end
    checkOutput("tx_level", bus.tx_level, mTxQ.size());
    checkOutput("send_buff_ready", bus.send_buff_ready, mTxQ.size() < BO);
    checkOutput("rx_level", bus.rx_level, mRxQ.size());
    checkOutput("recv_buff_ready", bus.recv_buff_ready, mRxQ.size() != 0);
    if (mRxQ.size() != 0) checkOutput("recv", bus.recv, mRxQ[0]);
    checkOutput("rx_overflow", bus.rx_overflow, mOvf);
    checkOutput("rx_frame_err", bus.rx_frame_err, mFerr);
  end

  task automatic applyStimulus(input logic advSend, input logic [WS-1:0] sendWord, input logic advRecv,
                               input logic rxV, input logic rxS, input logic [BW-1:0] rxD, input logic lb);
    @(negedge clock);
    bus.adv_send = advSend;
    bus.send     = sendWord;
    bus.adv_recv = advRecv;
    bus.rx_valid = rxV;
    bus.rx_start = rxS;
    bus.rx       = rxD;
    bus.loopback = lb;
  endtask

  task automatic idle(input int n, input logic lb);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, lb);
  endtask

  task automatic pulseReset(input int n, input logic advSend, input logic [WS-1:0] sendWord);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      reset = 1'b0;
      bus.adv_send = advSend;
      bus.send = sendWord;
      bus.adv_recv = advSend;
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    reset = 1'b1;
  endtask

  task automatic sendRxWord(input logic [WS-1:0] w, input logic popOnLast);
    for (int k = 0; k < BEATS; k++)
      applyStimulus(1'b0, '0, popOnLast && (k == BEATS - 1), 1'b1, (k == 0), beatOf(w, k), 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rxPos;
    logic lb;
    logic rs;
    bus.adv_send = 1'b1;
    bus.send     = 8'hFF;
    bus.adv_recv = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_start = 1'b0;
    bus.rx       = '0;
    bus.loopback = 1'b0;
    reset        = 1'b0;

    // Reset held with push/pop requests asserted; nothing may be transmitted afterwards
    pulseReset(2, 1'b1, 8'hFF);
    checkOutput("reset_tx_valid", bus.tx_valid, 0);
    checkOutput("reset_send_ready", bus.send_buff_ready, 1);
    idle(6, 1'b0);

    // Single word 0xB4 -> beats 0,1,3,2
    applyStimulus(1'b1, 8'hB4, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle(8, 1'b0);

    // Burst of six words on consecutive cycles
    for (int i = 1; i <= 6; i++) applyStimulus(1'b1, WS'(8'h11 * i), 1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle(30, 1'b0);

    // Loopback of two words
    pulseReset(1, 1'b0, '0);
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(14, 1'b1);
    checkOutput("lb_recv_first", bus.recv, 8'hA5);
    checkOutput("lb_rx_level", bus.rx_level, 2);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    idle(1, 1'b1);
    checkOutput("lb_recv_second", bus.recv, 8'h3C);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    idle(1, 1'b1);
    checkOutput("lb_empty", bus.recv_buff_ready, 0);

    // Overflow: five words into a four-deep RX FIFO, then a pop on completion
    pulseReset(1, 1'b0, '0);
    sendRxWord(8'h81, 1'b0);
    sendRxWord(8'h42, 1'b0);
    sendRxWord(8'h24, 1'b0);
    sendRxWord(8'h18, 1'b0);
    sendRxWord(8'hC3, 1'b0);
    idle(1, 1'b0);
    checkOutput("ovf_level", bus.rx_level, 4);
    checkOutput("ovf_flag", bus.rx_overflow, 1);
    checkOutput("ovf_recv", bus.recv, 8'h81);
    sendRxWord(8'h99, 1'b1);
    idle(1, 1'b0);
    checkOutput("ovf_pop_level", bus.rx_level, 4);
    checkOutput("ovf_pop_recv", bus.recv, 8'h42);

    // Frame error: two stray beats then a properly framed 0x5A
    pulseReset(1, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    sendRxWord(8'h5A, 1'b0);
    idle(1, 1'b0);
    checkOutput("ferr_flag", bus.rx_frame_err, 1);
    checkOutput("ferr_recv", bus.recv, 8'h5A);

    // Reset in the middle of a transmitted word
    applyStimulus(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle(3, 1'b0);
    pulseReset(1, 1'b0, '0);
    checkOutput("midreset_tx_valid", bus.tx_valid, 0);
    checkOutput("midreset_flags", {bus.rx_frame_err, bus.rx_overflow}, 0);
    idle(4, 1'b0);

    // Randomised traffic, alternating between pin and loopback sources
    rxPos = 0;
    for (int seg = 0; seg < 8; seg++) begin
      lb = (seg % 3 == 1);
      if (seg == 4) pulseReset(1, 1'b1, 8'hFF);
      for (int c = 0; c < 180; c++) begin
        logic rv;
        rv = ($urandom_range(0, 9) < 7);
        rs = 1'b0;
        if (rv) begin
          rs = (rxPos == 0) || ($urandom_range(0, 49) == 0);
          if (rs) rxPos = 0;
          rxPos = (rxPos + 1) % BEATS;
        end
        applyStimulus($urandom_range(0, 1) == 1, WS'($urandom), $urandom_range(0, 9) < 4,
                      rv, rs, BW'($urandom), lb);
      end
    end
    idle(30, 1'b0);

    @(posedge clock);
    #1;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/serial_transceiver_fifo.md
Name: serial_transceiver_fifo

Overview:
Parametrised full-duplex serial transceiver. Word-wide TX and RX FIFOs sit behind a BANDWIDTH-lane serial link with beat framing (valid/start strobes). It replaces the single-buffer transceiver and adds:
- per-word FIFOs
- back-to-back serialisation
- RX deserialisation with frame alignment
- internal loopback and sticky error flags
It sits between the core word bus and the inter-chip serial pins.

Parameters:
BANDWIDTH, 1, serial lanes per beat; WORD_SIZE must be a multiple of BANDWIDTH (elaboration error otherwise)
WORD_SIZE, 8, bits per word
BUFFER_OUT, 4, TX FIFO depth in words (>=1)
BUFFER_IN, 4, RX FIFO depth in words (>=1)
BEATS (derived), WORD_SIZE/BANDWIDTH, beats per word
LVL_OUT_W / LVL_IN_W (derived), $clog2(BUFFER_OUT+1) / $clog2(BUFFER_IN+1)

Ports:
clock  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-low; sampled on posedge clock
adv_send  in  1  push request for send
send  in  WORD_SIZE  word to transmit
send_buff_ready  out  1  TX FIFO can accept a word this cycle
adv_recv  in  1  pop request for recv
recv  out  WORD_SIZE  head of RX FIFO (show-ahead)
recv_buff_ready  out  1  RX FIFO non-empty
tx  out  BANDWIDTH  serial data beat
tx_valid  out  1  tx carries a beat
tx_start  out  1  tx carries beat 0 of a word
rx  in  BANDWIDTH  serial data beat
rx_valid  in  1  rx carries a beat
rx_start  in  1  rx carries beat 0 of a word
loopback  in  1  1 = RX path takes internal tx/tx_valid/tx_start instead of rx pins
rx_overflow  out  1  sticky: a received word was dropped (RX full)
rx_frame_err  out  1  sticky: rx_start arrived mid-word
tx_level  out  LVL_OUT_W  TX FIFO occupancy
rx_level  out  LVL_IN_W  RX FIFO occupancy

Behaviour:
- Reset (reset==0 at posedge), even mid-word or mid-burst:
  - both FIFOs empty; serialiser idle; deserialiser beat index 0; partial words discarded
  - tx=0, tx_valid=0, tx_start=0, rx_overflow=0, rx_frame_err=0
  - levels 0, recv_buff_ready=0, send_buff_ready=1 after the reset edge
  - adv_send/adv_recv ignored while reset==0.
- Flags:
  - send_buff_ready = (tx_level < BUFFER_OUT), computed from registered occupancy at cycle start.
  - recv_buff_ready = (rx_level != 0).
- TX push: adv_send && send_buff_ready pushes send at the edge. A push while not ready is ignored, with no flag. A full FIFO does not accept a push even if the serialiser pops in the same cycle.
- Serialiser states:
  - IDLE: if the FIFO was non-empty at cycle start, pop the head into the shift register and go to SHIFT.
  - SHIFT: beats are driven from the registered tx; bit order is LSB first (beat k = word[k*BANDWIDTH +: BANDWIDTH]). tx_valid=1 on every beat; tx_start=1 on beat 0 only.
  - On beat BEATS-1, if the FIFO is non-empty the next word loads at the same edge, so the stream is gap-free. Otherwise go to IDLE with tx=0, tx_valid=0.
- TX latency: a word pushed at edge N appears as beat 0 at edge N+1 when the serialiser is idle. Occupancy counts words still in the FIFO, not the word in the shift register.
- Deserialiser input source: pins, or the registered tx/tx_valid/tx_start when loopback=1. Loopback adds no extra delay beyond the tx register.
- RX beat capture (source valid at an edge):
  - If start=1: the beat is stored as beat 0. If the beat index was nonzero, set rx_frame_err and discard the partial word.
  - Otherwise the beat is stored at the current index and the index increments.
  - Invalid cycles hold the index and the partial word.
- RX word completion: when beat BEATS-1 is captured, the word is written to the RX FIFO.
  - If the FIFO is full and no pop occurs that cycle: drop the word and set rx_overflow.
  - Full with a simultaneous pop: the write succeeds and no overflow is flagged.
- RX pop: adv_recv && recv_buff_ready pops at the edge. recv shows the new head after that edge. recv is don't-care when empty; the bench must not check it then.
- Simultaneous push and pop on either FIFO leaves the level unchanged. Pointers wrap modulo depth; non-power-of-two depths are supported.
- Sticky flags clear only on reset.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with adv_send=1, send=0xFF -> tx=0, tx_valid=0, levels=0, send_buff_ready=1, recv_buff_ready=0; nothing is transmitted afterwards.
2. Single word, BANDWIDTH=2, WORD_SIZE=8: push 0xB4 at edge N -> tx beats 0,1,3,2 on edges N+1..N+4; tx_start only at N+1; tx_valid=0 at N+5.
3. Burst: push 0x11,0x22,0x33,0x44,0x55,0x66 on consecutive cycles, BUFFER_OUT=4 -> tx_valid is contiguous across all accepted words; tx_level never exceeds 4; words pushed while send_buff_ready=0 are absent from the stream.
4. Loopback: loopback=1, push 0xA5 then 0x3C, no adv_recv -> recv_buff_ready rises; recv=0xA5, rx_level=2; pop -> recv=0x3C; pop -> recv_buff_ready=0.
5. Overflow: BUFFER_IN=4, drive 5 framed words on rx with no pops -> rx_level=4, rx_overflow=1, recv=first word. Then pop while a 6th word completes -> that word is accepted; rx_level stays 4.
6. Frame error: drive 2 beats, then rx_start with a full word 0x5A -> rx_frame_err=1, recv=0x5A. Assert reset mid-TX-word -> tx_valid=0 on the next cycle and flags clear.
